// File: rtl/sd_arb_pkg.sv
// -----------------------------------------------------------------------------
// sd_arb_pkg
// Shared types and helpers for the SD drive arbiter. It holds the arbiter
// state encoding and the width helpers used to size the buffer bus and the
// grant index from the top-level parameters.
// -----------------------------------------------------------------------------
package sd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_XFER  = 2'd2,
        ST_GUARD = 2'd3
    } arb_state_e;

    // MSB index of the buffer read-back bus: 8-bit (7) or 16-bit (15).
    function automatic int dw(input int wide);
        return (wide != 0) ? 15 : 7;
    endfunction

    // Width of a drive index; at least one bit even for degenerate N.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sd_drive_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Pure combinational round-robin search. It returns the first pending drive
// at or after the pointer, wrapping from N-1 back to 0.
// Ports:
//   pend_i  [N-1:0]    pending request per drive
//   ptr_i   [IDW-1:0]  round-robin start position
//   found_o            at least one drive is pending
//   idx_o   [IDW-1:0]  index of the selected drive (0 when none found)
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   pend_i,
    input  logic [IDW-1:0] ptr_i,
    output logic           found_o,
    output logic [IDW-1:0] idx_o
);

    logic [IDW-1:0] pos_s;

    // Scan from the farthest offset down to offset 0 so the nearest pending
    // drive after the pointer is the last one written and therefore wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = {IDW{1'b0}};
        pos_s   = {IDW{1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            pos_s   = IDW'((int'(ptr_i) + k) % N);
            found_o = found_o | pend_i[pos_s];
            idx_o   = pend_i[pos_s] ? pos_s : idx_o;
        end
    end

endmodule

// File: rtl/sd_drive_arbiter.sv
// -----------------------------------------------------------------------------
// sd_drive_arbiter
// Shares the single host SD block channel among N image_card drives. In IDLE
// it picks one pending sector request round-robin and forwards it to the host.
// It then routes sd_ack and the buffer read-back to the granted drive only. A
// guard interval after each transfer lets the drive-side synchronizers drop
// their request before the next arbitration.
// Ports:
//   clk_sys, reset_n          clock, asynchronous active-low reset
//   req_rd/req_wr  [N-1:0]    per-drive read/write request levels
//   req_lba        [N*32-1:0] per-drive LBA, drive i at [32*i +: 32]
//   req_buff_din   [N*(DW+1)] per-drive buffer read-back
//   req_ack        [N-1:0]    per-drive ack (only the granted bit follows sd_ack)
//   sd_lba/sd_rd/sd_wr        registered request towards the host
//   sd_ack                    host ack, high for the whole transfer
//   sd_buff_din    [DW:0]     read-back of the granted drive, 0 when not busy
//   grant_id       [IDW-1:0]  granted drive, valid while busy
//   busy                      high from grant until the guard interval expires
// GUARD must be at least 1.
// -----------------------------------------------------------------------------
module sd_drive_arbiter
    import sd_arb_pkg::*;
#(
    parameter  int N     = 2,
    parameter  int WIDE  = 0,
    parameter  int GUARD = 8,
    localparam int DW    = dw(WIDE),
    localparam int IDW   = idw(N)
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic [N-1:0]        req_rd,
    input  logic [N-1:0]        req_wr,
    input  logic [N*32-1:0]     req_lba,
    input  logic [N*(DW+1)-1:0] req_buff_din,
    output logic [N-1:0]        req_ack,
    output logic [31:0]         sd_lba,
    output logic                sd_rd,
    output logic                sd_wr,
    input  logic                sd_ack,
    output logic [DW:0]         sd_buff_din,
    output logic [IDW-1:0]      grant_id,
    output logic                busy
);

    localparam int CW = (GUARD > 1) ? $clog2(GUARD) : 1;

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [31:0]    lba_q, lba_d;
    logic           rd_q, rd_d;
    logic           wr_q, wr_d;
    logic           busy_q, busy_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [N-1:0]   pend_s;
    logic           found_s;
    logic [IDW-1:0] pick_s;
    logic [31:0]    lba_arr_s  [N];
    logic [DW:0]    buff_arr_s [N];

    // Unpack the flat per-drive buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            lba_arr_s[i]  = req_lba[32*i +: 32];
            buff_arr_s[i] = req_buff_din[(DW+1)*i +: DW+1];
        end
    end

    assign pend_s = req_rd | req_wr;

    rr_picker #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_picker (
        .pend_i  (pend_s),
        .ptr_i   (rr_q),
        .found_o (found_s),
        .idx_o   (pick_s)
    );

    // State register and all registered grant/request state.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= {IDW{1'b0}};
            rr_q    <= {IDW{1'b0}};
            lba_q   <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: arbitration in IDLE, handshake tracking, guard countdown.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    grant_d = pick_s;
                    lba_d   = lba_arr_s[pick_s];
                    rd_d    = req_rd[pick_s];
                    // Read wins when a drive raises both.
                    wr_d    = req_wr[pick_s] & ~req_rd[pick_s];
                    busy_d  = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // The request is not withdrawn if the drive drops it here;
                // the host has already been asked and will answer.
                if (sd_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_XFER: begin
                if (!sd_ack) begin
                    rr_d    = (grant_q == IDW'(N - 1)) ? {IDW{1'b0}} : grant_q + IDW'(1);
                    cnt_d   = CW'(GUARD - 1);
                    state_d = ST_GUARD;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_GUARD: begin
                if (cnt_q == {CW{1'b0}}) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Output logic: the ack fan-out stays combinational so a host buffer write
    // on the ack-rise cycle already reaches the drive, which gates wren by ack.
    always_comb begin
        req_ack     = {N{1'b0}};
        sd_buff_din = {(DW+1){1'b0}};
        if (busy_q) begin
            req_ack[grant_q] = sd_ack;
            sd_buff_din      = buff_arr_s[grant_q];
        end else begin
            req_ack     = {N{1'b0}};
            sd_buff_din = {(DW+1){1'b0}};
        end
    end

    assign sd_lba   = lba_q;
    assign sd_rd    = rd_q;
    assign sd_wr    = wr_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sd_drive_arbiter
// Self-checking bench for sd_drive_arbiter (N=2, 8-bit buffer, GUARD=8).
// The reference model keeps only the round-robin pointer as an integer and
// derives every grant, ack pattern and guard length from it.
// -----------------------------------------------------------------------------
module tb_sd_drive_arbiter;
    import sd_arb_pkg::*;

    localparam int N     = 2;
    localparam int WIDE  = 0;
    localparam int GUARD = 8;
    localparam int DW    = dw(WIDE);
    localparam int IDW   = idw(N);

    logic                clk_sys = 1'b0;
    logic                reset_n = 1'b0;
    logic [N-1:0]        req_rd  = '0;
    logic [N-1:0]        req_wr  = '0;
    logic [N*32-1:0]     req_lba = '0;
    logic [N*(DW+1)-1:0] req_buff_din = '0;
    logic                sd_ack  = 1'b0;
    logic [N-1:0]        req_ack;
    logic [31:0]         sd_lba;
    logic                sd_rd;
    logic                sd_wr;
    logic [DW:0]         sd_buff_din;
    logic [IDW-1:0]      grant_id;
    logic                busy;

    int n_chk  = 0;
    int n_fail = 0;
    int rr_m   = 0;

    sd_drive_arbiter #(.N(N), .WIDE(WIDE), .GUARD(GUARD)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_lba      (req_lba),
        .req_buff_din (req_buff_din),
        .req_ack      (req_ack),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_din  (sd_buff_din),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // First pending drive at or after the model pointer, -1 if none.
    function automatic int model_pick(input logic [N-1:0] rd, input logic [N-1:0] wr);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (rr_m + k) % N;
            if (rd[j] | wr[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_sd_rd"}, sd_rd, 0);
        chk({tag, "_sd_wr"}, sd_wr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_req_ack"}, req_ack, 0);
        chk({tag, "_buff"}, sd_buff_din, 0);
    endtask

    // One full request/ack/guard transaction checked against the model.
    task automatic run_txn(input logic [N-1:0] rd, input logic [N-1:0] wr,
                           input logic [N*32-1:0] lbas, input int ack_len, input int req_wait);
        int g;
        int cnt;
        @(negedge clk_sys);
        req_rd  = rd;
        req_wr  = wr;
        req_lba = lbas;
        for (int i = 0; i < N; i++) req_buff_din[i*(DW+1) +: DW+1] = (DW+1)'($urandom);
        g = model_pick(rd, wr);
        if (g < 0) begin
            @(negedge clk_sys);
            chk("noreq_busy", busy, 0);
            chk("noreq_sd_rd", sd_rd, 0);
            return;
        end
        @(negedge clk_sys);
        chk("grant_id", grant_id, g);
        chk("sd_lba", sd_lba, lbas[g*32 +: 32]);
        chk("sd_rd", sd_rd, rd[g]);
        chk("sd_wr", sd_wr, wr[g] & ~rd[g]);
        chk("busy_grant", busy, 1);
        chk("req_ack_pre", req_ack, 0);
        repeat (req_wait) @(negedge clk_sys);
        if (req_wait > 0) begin
            chk("sd_rd_hold", sd_rd, rd[g]);
            chk("sd_lba_hold", sd_lba, lbas[g*32 +: 32]);
        end
        sd_ack = 1'b1;
        #1;
        chk("req_ack_rise", req_ack, N'(1) << g);
        chk("buff_mux_rise", sd_buff_din, req_buff_din[g*(DW+1) +: DW+1]);
        req_rd[g] = 1'b0;
        req_wr[g] = 1'b0;
        @(negedge clk_sys);
        chk("sd_rd_clear", sd_rd, 0);
        chk("sd_wr_clear", sd_wr, 0);
        for (int c = 1; c < ack_len; c++) begin
            req_buff_din = (N*(DW+1))'({$urandom, $urandom});
            #1;
            chk("req_ack_xfer", req_ack, N'(1) << g);
            chk("buff_mux_xfer", sd_buff_din, req_buff_din[g*(DW+1) +: DW+1]);
            @(negedge clk_sys);
        end
        sd_ack = 1'b0;
        rr_m   = (g + 1) % N;
        cnt    = 0;
        do begin
            @(posedge clk_sys);
            cnt++;
            @(negedge clk_sys);
        end while (busy && cnt < 100);
        // Edges from the ack-low sample edge through the guard countdown.
        chk("guard_len", cnt, GUARD + 1);
        req_rd = '0;
        req_wr = '0;
    endtask

    initial begin
        int w;
        int cnt;
        // ---- reset state ----
        #12;
        chk_quiet("reset");
        chk("reset_grant", grant_id, 0);
        chk("reset_lba", sd_lba, 0);
        @(negedge clk_sys);
        reset_n = 1'b1;

        // ---- single read, drive 0, long transfer ----
        run_txn(2'b01, 2'b00, {32'h0, 32'h0000_1234}, 512, 2);
        // ---- write path, drive 1 ----
        run_txn(2'b00, 2'b10, {32'h0000_0020, 32'h0}, 20, 1);
        // ---- read and write together on drive 0: read wins ----
        run_txn(2'b01, 2'b01, {32'h0, 32'h0000_0777}, 5, 0);

        // ---- unsolicited sd_ack in IDLE ----
        @(negedge clk_sys);
        sd_ack = 1'b1;
        #1;
        chk("spurious_ack", req_ack, 0);
        @(negedge clk_sys);
        sd_ack = 1'b0;
        chk_quiet("spurious_after");
        @(negedge clk_sys);
        chk("spurious_idle", busy, 0);

        // ---- randomized transactions ----
        for (int t = 0; t < 40; t++) begin
            run_txn(N'($urandom_range(0, 3)), N'($urandom_range(0, 3)),
                    (N*32)'({$urandom, $urandom}), $urandom_range(1, 30), $urandom_range(0, 3));
        end

        // ---- round robin with both drives reading continuously ----
        @(negedge clk_sys);
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        rr_m    = 0;
        req_rd  = 2'b11;
        for (int t = 0; t < 4; t++) begin
            w = 0;
            while (!sd_rd && w < 50) begin
                @(negedge clk_sys);
                w++;
            end
            chk("rr_wait", w < 50, 1);
            chk("rr_grant", grant_id, model_pick(2'b11, 2'b00));
            sd_ack = 1'b1;
            repeat (4) @(negedge clk_sys);
            sd_ack = 1'b0;
            rr_m   = (rr_m + 1) % N;
            if (t < 3) begin
                @(posedge clk_sys);
                cnt = 0;
                do begin
                    @(posedge clk_sys);
                    cnt++;
                    @(negedge clk_sys);
                end while (!sd_rd && cnt < 50);
                chk("rr_gap", cnt, GUARD + 1);
            end else begin
                req_rd = 2'b00;
            end
        end
        w = 0;
        while (busy && w < 50) begin
            @(negedge clk_sys);
            w++;
        end

        // ---- reset in the middle of a transfer ----
        run_txn(2'b01, 2'b00, {32'h0, 32'h0000_0abc}, 3, 0);
        @(negedge clk_sys);
        req_rd = 2'b11;
        @(negedge clk_sys);
        chk("pre_abort_grant", grant_id, model_pick(2'b11, 2'b00));
        sd_ack = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        chk_quiet("abort");
        chk("abort_lba", sd_lba, 0);
        chk("abort_grant", grant_id, 0);
        sd_ack = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        rr_m    = 0;
        @(negedge clk_sys);
        chk("regrant_id", grant_id, model_pick(2'b11, 2'b00));
        chk("regrant_rd", sd_rd, 1);
        chk("regrant_busy", busy, 1);
        req_rd = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
